spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave_if.sv | 34 +++
 rtl/spi_slave.sv | 165 ++++++++++++++++
 tb/tb_spi_slave.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_if
// Purpose  : SPI pins plus the byte-level tx/rx handshake of spi_slave.
//            The slave modport is the design's view; the master modport is
//            the view of whatever drives the pins and the byte handshake.
// Revision : 1.0  initial release
// ============================================================================
interface spi_slave_if;
  logic       SS;
  logic       SCLK;
  logic       MOSI;
  logic       MISO;
  logic [7:0] txData;
  logic       txWr;
  logic       txRdy;
  logic [7:0] rxData;
  logic       rxValid;
  logic       rxAck;
  logic       ovr;
  logic       ovrClr;
  logic       busy;

  modport slave (
    input  SS, SCLK, MOSI, txData, txWr, rxAck, ovrClr,
    output MISO, txRdy, rxData, rxValid, ovr, busy
  );

  modport master (
    output SS, SCLK, MOSI, txData, txWr, rxAck, ovrClr,
    input  MISO, txRdy, rxData, rxValid, ovr, busy
  );
endinterface
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave
// Purpose  : SPI mode-0 byte slave, 8-bit frames MSbit first. The SPI pins are
//            oversampled by clk through 2-flop synchronizers, with one tx
//            holding register and one rx data register.
// Revision : 1.0  initial release
// ============================================================================
module spi_slave (
  input  logic        clk,
  input  logic        rst,   // asynchronous, active-low
  spi_slave_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t     state;

  logic       ss_s1, ss_s2, ss_s3;
  logic       sclk_s1, sclk_s2, sclk_s3;
  logic       mosi_s1, mosi_s2;

  logic [2:0] bit_cnt;
  logic [7:0] rx_shift;
  logic [7:0] tx_shift;
  logic       reload_pend;   // 8th rising edge seen, reload on next falling
  logic       busy_q;

  logic [7:0] tx_hold;
  logic       tx_rdy;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       ovr_q;

  logic       ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic       load_now;
  logic       byte_done;
  logic [7:0] rx_byte;

  // Synchronize the asynchronous pins; stage 3 exists only for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ss_s1   <= 1'b1;
      ss_s2   <= 1'b1;
      ss_s3   <= 1'b1;
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      ss_s1   <= bus.SS;
      ss_s2   <= ss_s1;
      ss_s3   <= ss_s2;
      sclk_s1 <= bus.SCLK;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      mosi_s1 <= bus.MOSI;
      mosi_s2 <= mosi_s1;
    end
  end

  assign ss_fall   =  ss_s3   & ~ss_s2;
  assign ss_rise   = ~ss_s3   &  ss_s2;
  assign sclk_rise = ~sclk_s3 &  sclk_s2;
  assign sclk_fall =  sclk_s3 & ~sclk_s2;

  // A deselect takes priority over any SCLK edge detected in the same cycle.
  assign load_now  = ((state == IDLE) && ss_fall) ||
                     ((state == SHIFT) && !ss_rise && sclk_fall && reload_pend);
  assign byte_done = (state == SHIFT) && !ss_rise && sclk_rise && (bit_cnt == 3'd7);
  assign rx_byte   = {rx_shift[6:0], mosi_s2};

  // Frame FSM: owns the bit counter and both shift registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      rx_shift    <= 8'h00;
      tx_shift    <= 8'hFF;
      reload_pend <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ss_fall) begin
            state       <= SHIFT;
            busy_q      <= 1'b1;
            bit_cnt     <= 3'd0;
            reload_pend <= 1'b0;
            tx_shift    <= tx_rdy ? 8'hFF : tx_hold;
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            // Abort: the partial rx byte and the loaded tx byte are dropped.
            state       <= IDLE;
            busy_q      <= 1'b0;
            bit_cnt     <= 3'd0;
            reload_pend <= 1'b0;
          end else if (sclk_rise) begin
            rx_shift    <= rx_byte;
            bit_cnt     <= bit_cnt + 3'd1;
            reload_pend <= (bit_cnt == 3'd7);
          end else if (sclk_fall) begin
            if (reload_pend) begin
              tx_shift    <= tx_rdy ? 8'hFF : tx_hold;
              reload_pend <= 1'b0;
            end else begin
              tx_shift    <= {tx_shift[6:0], 1'b1};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tx holding register: a load empties it, a write is accepted only when empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_hold <= 8'h00;
      tx_rdy  <= 1'b1;
    end else if (load_now && !tx_rdy) begin
      tx_rdy  <= 1'b1;
    end else if (bus.txWr && tx_rdy) begin
      tx_hold <= bus.txData;
      tx_rdy  <= 1'b0;
    end
  end

  // Rx data register with overrun detection; a new byte beats an acknowledge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      if (byte_done) begin
        rx_data  <= rx_byte;
        rx_valid <= 1'b1;
      end else if (bus.rxAck) begin
        rx_valid <= 1'b0;
      end

      if (byte_done && rx_valid && !bus.rxAck) begin
        ovr_q <= 1'b1;
      end else if (bus.ovrClr) begin
        ovr_q <= 1'b0;
      end
    end
  end

  assign bus.MISO    = (state == SHIFT) ? tx_shift[7] : 1'b1;
  assign bus.txRdy   = tx_rdy;
  assign bus.rxData  = rx_data;
  assign bus.rxValid = rx_valid;
  assign bus.ovr     = ovr_q;
  assign bus.busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave
// Purpose  : Directed bench for spi_slave acting as a mode-0 SPI master at
//            SCLK = clk/64, with queues holding the expected MISO/rx bytes.
// Revision : 1.0  initial release
// ============================================================================
module tb_spi_slave;

  logic clk;
  logic rst;

  spi_slave_if bus ();

  spi_slave dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rv_rise = 0;
  int rv_base;
  logic rv_prev = 1'b0;

  logic [7:0] exp_miso_q[$];
  logic [7:0] exp_rx_q[$];
  logic [7:0] m;

  // Count rising edges of rxValid so pulses per frame can be verified.
  always @(negedge clk) begin
    if (bus.rxValid && !rv_prev) rv_rise = rv_rise + 1;
    rv_prev = bus.rxValid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_write(input logic [7:0] d);
    @(negedge clk);
    bus.txData = d;
    bus.txWr   = 1'b1;
    @(negedge clk);
    bus.txWr   = 1'b0;
  endtask

  task automatic ss_low();
    @(negedge clk);
    bus.SS = 1'b0;
    clks(8);
  endtask

  task automatic ss_high();
    clks(32);
    bus.SS = 1'b1;
    clks(8);
  endtask

  // Shift n bits of d (MSbit first); MISO is sampled just before each rise.
  task automatic xfer(input logic [7:0] d, input int n, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < n; i++) begin
      bus.MOSI = d[7-i];
      clks(32);
      mi = {mi[6:0], bus.MISO};
      bus.SCLK = 1'b1;
      clks(32);
      bus.SCLK = 1'b0;
    end
  endtask

  task automatic cmp_miso(input logic [7:0] mi);
    if (exp_miso_q.size() == 0) begin
      checks++; errors++;
      $error("FAIL miso_queue: observed=empty expected=entry");
    end else begin
      check("miso_byte", {24'h0, mi}, {24'h0, exp_miso_q.pop_front()});
    end
  endtask

  task automatic cmp_rx();
    check("rx_valid", {31'h0, bus.rxValid}, 32'd1);
    if (exp_rx_q.size() == 0) begin
      checks++; errors++;
      $error("FAIL rx_queue: observed=empty expected=entry");
    end else begin
      check("rx_data", {24'h0, bus.rxData}, {24'h0, exp_rx_q.pop_front()});
    end
  endtask

  task automatic ack();
    @(negedge clk);
    bus.rxAck = 1'b1;
    @(negedge clk);
    bus.rxAck = 1'b0;
    clks(1);
    check("rx_valid_after_ack", {31'h0, bus.rxValid}, 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_miso"},    {31'h0, bus.MISO},    32'd1);
    check({tag, "_txrdy"},   {31'h0, bus.txRdy},   32'd1);
    check({tag, "_rxvalid"}, {31'h0, bus.rxValid}, 32'd0);
    check({tag, "_rxdata"},  {24'h0, bus.rxData},  32'h00);
    check({tag, "_ovr"},     {31'h0, bus.ovr},     32'd0);
    check({tag, "_busy"},    {31'h0, bus.busy},    32'd0);
  endtask

  initial begin
    bus.SS = 1'b1; bus.SCLK = 1'b0; bus.MOSI = 1'b0;
    bus.txData = 8'h00; bus.txWr = 1'b0; bus.rxAck = 1'b0; bus.ovrClr = 1'b0;
    rst = 1'b0;
    clks(5);
    check_reset_state("reset");
    rst = 1'b1;
    clks(5);

    // Loaded byte goes out while 8'h3C comes in.
    tx_write(8'hA5);
    check("txrdy_after_write", {31'h0, bus.txRdy}, 32'd0);
    exp_miso_q.push_back(8'hA5); exp_rx_q.push_back(8'h3C);
    ss_low();
    check("busy_selected", {31'h0, bus.busy}, 32'd1);
    check("txrdy_after_load", {31'h0, bus.txRdy}, 32'd1);
    xfer(8'h3C, 8, m);
    cmp_miso(m);
    cmp_rx();
    ack();
    ss_high();
    check("busy_deselected", {31'h0, bus.busy}, 32'd0);
    check("miso_idle", {31'h0, bus.MISO}, 32'd1);

    // Empty holding register: two 8'hFF bytes, two rxValid pulses.
    rv_base = rv_rise;
    ss_low();
    exp_miso_q.push_back(8'hFF); exp_rx_q.push_back(8'h01);
    xfer(8'h01, 8, m); cmp_miso(m); cmp_rx(); ack();
    exp_miso_q.push_back(8'hFF); exp_rx_q.push_back(8'h02);
    xfer(8'h02, 8, m); cmp_miso(m); cmp_rx(); ack();
    ss_high();
    check("rxvalid_pulses_two", rv_rise - rv_base, 32'd2);
    check("ovr_clean", {31'h0, bus.ovr}, 32'd0);

    // Overrun: second byte without acknowledge.
    ss_low();
    exp_miso_q.push_back(8'hFF); exp_rx_q.push_back(8'h11);
    xfer(8'h11, 8, m); cmp_miso(m); cmp_rx();
    check("ovr_before", {31'h0, bus.ovr}, 32'd0);
    exp_miso_q.push_back(8'hFF); exp_rx_q.push_back(8'h22);
    xfer(8'h22, 8, m); cmp_miso(m); cmp_rx();
    check("ovr_set", {31'h0, bus.ovr}, 32'd1);
    ss_high();
    @(negedge clk); bus.ovrClr = 1'b1;
    @(negedge clk); bus.ovrClr = 1'b0;
    clks(1);
    check("ovr_cleared", {31'h0, bus.ovr}, 32'd0);
    ack();

    // Back-to-back writes: the second one is ignored.
    @(negedge clk);
    bus.txData = 8'h5A; bus.txWr = 1'b1;
    @(negedge clk);
    bus.txData = 8'hC3;
    @(negedge clk);
    bus.txWr = 1'b0;
    check("txrdy_b2b", {31'h0, bus.txRdy}, 32'd0);
    exp_miso_q.push_back(8'h5A); exp_rx_q.push_back(8'h00);
    ss_low();
    xfer(8'h00, 8, m); cmp_miso(m); cmp_rx(); ack();
    ss_high();
    check("txrdy_b2b_after", {31'h0, bus.txRdy}, 32'd1);

    // Aborted partial frame, then a full one.
    rv_base = rv_rise;
    ss_low();
    xfer(8'hA0, 2, m);
    ss_high();
    check("abort_no_pulse", rv_rise - rv_base, 32'd0);
    check("abort_rxvalid", {31'h0, bus.rxValid}, 32'd0);
    exp_miso_q.push_back(8'hFF); exp_rx_q.push_back(8'h81);
    ss_low();
    xfer(8'h81, 8, m); cmp_miso(m); cmp_rx(); ack();
    ss_high();
    check("abort_single_pulse", rv_rise - rv_base, 32'd1);

    // Reset in the middle of a frame, then a clean frame.
    ss_low();
    tx_write(8'h77);
    check("txrdy_pre_reset", {31'h0, bus.txRdy}, 32'd0);
    xfer(8'hAA, 5, m);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check_reset_state("midreset");
    bus.SS = 1'b1;
    clks(4);
    rst = 1'b1;
    clks(4);
    exp_miso_q.push_back(8'hFF); exp_rx_q.push_back(8'hF0);
    ss_low();
    xfer(8'hF0, 8, m); cmp_miso(m); cmp_rx(); ack();
    ss_high();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
